alu8_nibble_seq: RTL and testbench

- 8-bit ALU sequencer for the CPU datapath. Splits each 8-bit operation into two passes through the existing 4-bit nibble ALU: low nibble first, high nibble second.
- Drives the nibble ALU's inputs and consumes its outputs through dedicated ports.
- Assembles the 8-bit result and the Z/N/H/C flags, and returns them to the execute stage with a valid/ready handshake.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu8_opmap.sv | 57 +++++
 rtl/alu8_nibble_seq.sv | 183 ++++++++++++++++++
 tb/tb_alu8_nibble_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU sequencer: opcodes, FSM states and
// flag bit positions within the F byte.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_ADC = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_SBC = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  // Arithmetic ops propagate carry/borrow between nibbles; logical ops do not.
  function automatic logic is_arith(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
           (op == OP_SBC) || (op == OP_CP);
  endfunction

endpackage

// File: rtl/alu8_opmap.sv
// Combinational opcode mapper: chooses the nibble ALU opcode and carry-in for
// each pass, and derives the N/H/C flag values for the 8-bit result.
module alu8_opmap
  import alu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic                phase_hi,
  input  logic                cf,
  input  logic                lo_c,
  input  logic                hi_c,
  output logic [ALU_OP_W-1:0] nib_op,
  output logic                nib_cin,
  output logic                flag_n,
  output logic                flag_h,
  output logic                flag_c
);

  // Low pass uses the requested op; high pass chains the low-nibble carry.
  always_comb begin
    nib_op  = op;
    nib_cin = 1'b0;
    unique case (op)
      OP_ADD: begin
        nib_op  = phase_hi ? OP_ADC : OP_ADD;
        nib_cin = phase_hi ? lo_c : 1'b0;
      end
      OP_ADC: begin
        nib_op  = OP_ADC;
        nib_cin = phase_hi ? lo_c : cf;
      end
      OP_SUB: begin
        nib_op  = phase_hi ? OP_SBC : OP_SUB;
        nib_cin = phase_hi ? lo_c : 1'b0;
      end
      OP_SBC: begin
        nib_op  = OP_SBC;
        nib_cin = phase_hi ? lo_c : cf;
      end
      OP_CP: begin
        nib_op  = OP_CP;
        nib_cin = phase_hi ? lo_c : 1'b0;
      end
      default: begin
        nib_op  = op;
        nib_cin = 1'b0;
      end
    endcase
  end

  // Flag rules: N marks subtraction, H is the inter-nibble carry (or 1 for AND).
  always_comb begin
    flag_n = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    flag_h = is_arith(op) ? lo_c : (op == OP_AND);
    flag_c = is_arith(op) ? hi_c : 1'b0;
  end

endmodule

// File: rtl/alu8_nibble_seq.sv
// 8-bit ALU sequencer: runs each operation as two passes (low nibble, then
// high nibble) through an external 4-bit nibble ALU and returns the byte
// result with Z/N/H/C over a valid/ready handshake.
// Optional macro ALU8_BACK2BACK_EN: accept the next request in DONE while the
// current result is being consumed, giving one op every 3 cycles.
module alu8_nibble_seq
  import alu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic [OP_W-1:0] in_op,
  input  logic            in_cf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_res,
  output logic            out_z,
  output logic            out_n,
  output logic            out_h,
  output logic            out_c,
  output logic [3:0]      nib_a,
  output logic [3:0]      nib_b,
  output logic [2:0]      nib_op,
  output logic            nib_cin,
  input  logic [3:0]      nib_out,
  input  logic            nib_z,
  input  logic            nib_c
);

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      res_q, res_d;
  logic [7:4]      flags_q, flags_d;
  logic [3:0]      nib_a_q, nib_a_d, nib_b_q, nib_b_d;
  logic [2:0]      nib_op_q, nib_op_d;
  logic            nib_cin_q, nib_cin_d;
  logic [3:0]      a_hi_q, a_hi_d, b_hi_q, b_hi_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            lo_z_q, lo_z_d, lo_c_q, lo_c_d;

  logic            accept;
  logic            in_flight;
  logic [2:0]      map_op, map_nib_op;
  logic            map_cin, map_n, map_h, map_c;

  // Accept in IDLE; optionally also in DONE when the result is being taken.
  always_comb begin
`ifdef ALU8_BACK2BACK_EN
    in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
`else
    in_ready = (state_q == ST_IDLE);
`endif
  end

  assign accept    = in_valid && in_ready;
  assign in_flight = (state_q == ST_LO) || (state_q == ST_HI);
  assign map_op    = in_flight ? op_q : in_op;

  // In LO the mapper prepares the high pass (lo_c is the live nibble carry);
  // in HI it evaluates flags from the latched lo_c and the live high carry.
  alu8_opmap u_opmap (
    .op       (map_op),
    .phase_hi (state_q == ST_LO),
    .cf       (in_cf),
    .lo_c     ((state_q == ST_LO) ? nib_c : lo_c_q),
    .hi_c     (nib_c),
    .nib_op   (map_nib_op),
    .nib_cin  (map_cin),
    .flag_n   (map_n),
    .flag_h   (map_h),
    .flag_c   (map_c)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    flags_d     = flags_q;
    nib_a_d     = nib_a_q;
    nib_b_d     = nib_b_q;
    nib_op_d    = nib_op_q;
    nib_cin_d   = nib_cin_q;
    a_hi_d      = a_hi_q;
    b_hi_d      = b_hi_q;
    op_d        = op_q;
    lo_z_d      = lo_z_q;
    lo_c_d      = lo_c_q;
    unique case (state_q)
      ST_IDLE: ;
      ST_LO: begin
        res_d[3:0] = nib_out;
        lo_z_d     = nib_z;
        lo_c_d     = nib_c;
        nib_a_d    = a_hi_q;
        nib_b_d    = b_hi_q;
        nib_op_d   = map_nib_op;
        nib_cin_d  = map_cin;
        state_d    = ST_HI;
      end
      ST_HI: begin
        res_d[7:4]      = nib_out;
        flags_d[FLAG_Z] = lo_z_q & nib_z;
        flags_d[FLAG_N] = map_n;
        flags_d[FLAG_H] = map_h;
        flags_d[FLAG_C] = map_c;
        nib_a_d         = 4'h0;
        nib_b_d         = 4'h0;
        nib_op_d        = 3'd0;
        nib_cin_d       = 1'b0;
        out_valid_d     = 1'b1;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Acceptance overrides the IDLE/DONE defaults and loads the low pass.
    if (accept) begin
      a_hi_d    = in_a[7:4];
      b_hi_d    = in_b[7:4];
      op_d      = in_op;
      nib_a_d   = in_a[3:0];
      nib_b_d   = in_b[3:0];
      nib_op_d  = map_nib_op;
      nib_cin_d = map_cin;
      state_d   = ST_LO;
    end
  end

  // Control state and registered outputs, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= 8'h00;
      flags_q     <= 4'h0;
      nib_a_q     <= 4'h0;
      nib_b_q     <= 4'h0;
      nib_op_q    <= 3'd0;
      nib_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      nib_a_q     <= nib_a_d;
      nib_b_q     <= nib_b_d;
      nib_op_q    <= nib_op_d;
      nib_cin_q   <= nib_cin_d;
    end
  end

  // Operand and intermediate-carry holding registers; only read while in flight.
  always_ff @(posedge clk) begin
    a_hi_q <= a_hi_d;
    b_hi_q <= b_hi_d;
    op_q   <= op_d;
    lo_z_q <= lo_z_d;
    lo_c_q <= lo_c_d;
  end

  assign out_valid = out_valid_q;
  assign out_res   = res_q;
  assign out_z     = flags_q[FLAG_Z];
  assign out_n     = flags_q[FLAG_N];
  assign out_h     = flags_q[FLAG_H];
  assign out_c     = flags_q[FLAG_C];
  assign nib_a     = nib_a_q;
  assign nib_b     = nib_b_q;
  assign nib_op    = nib_op_q;
  assign nib_cin   = nib_cin_q;

endmodule

// File: tb/tb_alu8_nibble_seq.sv
// Directed bench for alu8_nibble_seq with a behavioural 4-bit nibble ALU.
module tb_alu8_nibble_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [2:0] in_op = 3'd0;
  logic       in_cf = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_res;
  logic       out_z, out_n, out_h, out_c;
  logic [3:0] nib_a, nib_b, nib_out;
  logic [2:0] nib_op;
  logic       nib_cin, nib_z, nib_c;

  int n_cmp = 0;
  int n_err = 0;

  alu8_nibble_seq #(.OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cf(in_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_z(out_z), .out_n(out_n), .out_h(out_h), .out_c(out_c),
    .nib_a(nib_a), .nib_b(nib_b), .nib_op(nib_op), .nib_cin(nib_cin),
    .nib_out(nib_out), .nib_z(nib_z), .nib_c(nib_c)
  );

  always #5 clk = ~clk;

  // Behavioural nibble ALU: carry out for add, borrow out for subtract/compare.
  logic [4:0] nsum;
  always_comb begin
    nsum    = 5'd0;
    nib_out = 4'h0;
    nib_c   = 1'b0;
    nib_z   = 1'b0;
    case (nib_op)
      3'd0: nsum = {1'b0, nib_a} + {1'b0, nib_b};
      3'd1: nsum = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_cin};
      3'd2: nsum = {1'b0, nib_a} - {1'b0, nib_b};
      3'd3: nsum = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, nib_cin};
      3'd4: nsum = {1'b0, nib_a & nib_b};
      3'd5: nsum = {1'b0, nib_a ^ nib_b};
      3'd6: nsum = {1'b0, nib_a | nib_b};
      default: nsum = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, nib_cin};
    endcase
    nib_c   = nsum[4];
    nib_z   = (nsum[3:0] == 4'h0);
    nib_out = (nib_op == 3'd7) ? nib_a : nsum[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through the full sequence; ef = {Z,N,H,C}.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic cf,
                       input logic [7:0] er, input logic [3:0] ef);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cf = cf;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op; in_cf = ~cf;
    chk({tag, " lo nib_a"}, nib_a, a[3:0]);
    chk({tag, " lo nib_b"}, nib_b, b[3:0]);
    chk({tag, " busy"}, {out_valid, in_ready}, 2'b00);
    @(posedge clk); #1;
    chk({tag, " hi nib_a"}, nib_a, a[7:4]);
    chk({tag, " hi vld"}, out_valid, 0);
    @(posedge clk); #1;
    chk({tag, " vld"}, out_valid, 1);
    chk({tag, " res"}, out_res, er);
    chk({tag, " flags"}, {out_z, out_n, out_h, out_c}, ef);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, " back idle"}, {out_valid, in_ready}, 2'b01);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst vld", out_valid, 0);
    chk("rst res", out_res, 8'h00);
    chk("rst flags", {out_z, out_n, out_h, out_c}, 4'h0);
    chk("rst nib", {nib_a, nib_b, nib_op, nib_cin}, 12'h000);
    chk("rst ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add",    8'h3A, 8'hC6, 3'd0, 1'b0, 8'h00, 4'b1011);
    do_op("add_cf", 8'h12, 8'h34, 3'd0, 1'b1, 8'h46, 4'b0000);
    do_op("sub",    8'h10, 8'h01, 3'd2, 1'b0, 8'h0F, 4'b0110);
    do_op("sbc",    8'h00, 8'h00, 3'd3, 1'b1, 8'hFF, 4'b0111);
    do_op("cp_eq",  8'h42, 8'h42, 3'd7, 1'b0, 8'h42, 4'b1100);
    do_op("cp_lt",  8'h42, 8'h43, 3'd7, 1'b0, 8'h42, 4'b0111);
    do_op("and",    8'hF0, 8'h0F, 3'd4, 1'b0, 8'h00, 4'b1010);
    do_op("or",     8'hF0, 8'h0F, 3'd6, 1'b0, 8'hFF, 4'b0000);
    do_op("xor",    8'h5A, 8'hFF, 3'd5, 1'b0, 8'hA5, 4'b0000);
    do_op("adc_wr", 8'hFF, 8'h00, 3'd1, 1'b1, 8'h00, 4'b1011);

    // Backpressure: result held for 5 cycles while a competing request waits
    out_ready = 1'b0;
    do_op("bp", 8'h01, 8'h01, 3'd0, 1'b0, 8'h02, 4'b0000);
    in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hFF; in_op = 3'd5; in_cf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold", {out_valid, in_ready, out_res}, {2'b10, 8'h02});
      chk("bp flags", {out_z, out_n, out_h, out_c}, 4'h0);
    end
`ifdef ALU8_BACK2BACK_EN
    out_ready = 1'b1;
    #1;
    chk("b2b ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b lo", {out_valid, nib_a, nib_b}, {1'b0, 4'hA, 4'hF});
    @(posedge clk); #1;
    chk("b2b hi", out_valid, 0);
    @(posedge clk); #1;
    chk("b2b vld", out_valid, 1);
    chk("b2b res", out_res, 8'hA5);
    @(posedge clk); #1;
    chk("b2b idle", {out_valid, in_ready}, 2'b01);
`else
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", {out_valid, in_ready}, 2'b01);
`endif

    // Reset during the high pass of ADC 0xFF+0x00+1
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h00; in_op = 3'd1; in_cf = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rp hi", {nib_a, nib_op, nib_cin}, {4'hF, 3'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("rp vld", out_valid, 0);
    chk("rp res", out_res, 8'h00);
    chk("rp flags", {out_z, out_n, out_h, out_c}, 4'h0);
    chk("rp ready", in_ready, 1);
    chk("rp nib", {nib_a, nib_b, nib_op, nib_cin}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("after_rst", 8'hFF, 8'h00, 3'd1, 1'b1, 8'h00, 4'b1011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
